board_input_conditioner: RTL and testbench

Conditions the raw board switches and buttons before they select the instruction the pipeline runs. It synchronizes and debounces the 4 switches and 3 buttons, decodes the debounced pattern into the 3-bit instruction select (lw/sw/beq/add/sub/and/or/slt), and registers it with valid and change strobes. It sits between the board pins and the board-level controller, so the pipeline never sees metastable, bouncing or undefined selects.

---
 rtl/board_input_conditioner_pkg.sv | 66 ++++++
 rtl/board_input_conditioner_if.sv | 28 ++
 rtl/board_input_conditioner_debouncer.sv | 79 +++++++
 rtl/board_input_conditioner.sv | 77 +++++++
 tb/tb_board_input_conditioner.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_input_conditioner_pkg.sv
// Shared select codes, board pin patterns and the select decoder for the
// board input conditioner.
package board_pkg;

  // Instruction select codes driven towards the pipeline
  localparam logic [2:0] SEL_LW  = 3'd0;
  localparam logic [2:0] SEL_SW  = 3'd1;
  localparam logic [2:0] SEL_BEQ = 3'd2;
  localparam logic [2:0] SEL_ADD = 3'd3;
  localparam logic [2:0] SEL_SUB = 3'd4;
  localparam logic [2:0] SEL_AND = 3'd5;
  localparam logic [2:0] SEL_OR  = 3'd6;
  localparam logic [2:0] SEL_SLT = 3'd7;

  // One-hot switch patterns
  localparam logic [3:0] SW_LW    = 4'b1000;
  localparam logic [3:0] SW_SW    = 4'b0100;
  localparam logic [3:0] SW_BEQ   = 4'b0010;
  localparam logic [3:0] SW_RTYPE = 4'b0001;

  // Button codes selecting the R-type function
  localparam logic [2:0] BTN_ADD = 3'b010;
  localparam logic [2:0] BTN_SUB = 3'b110;
  localparam logic [2:0] BTN_AND = 3'b000;
  localparam logic [2:0] BTN_OR  = 3'b001;
  localparam logic [2:0] BTN_SLT = 3'b111;

  // Width of the combined {switches, buttons} vector
  localparam int unsigned IN_WIDTH = 7;

  typedef enum logic {
    StSettling,
    StStable
  } deb_state_e;

  typedef struct packed {
    logic       legal;
    logic [2:0] code;
  } decode_t;

  // Map a committed switch/button pattern onto an instruction select.
  // Buttons only matter for the R-type switch pattern.
  function automatic decode_t decode_sel(input logic [3:0] sw, input logic [2:0] btn);
    decode_t d;
    d.legal = 1'b1;
    d.code  = SEL_LW;
    case (sw)
      SW_LW:  d.code = SEL_LW;
      SW_SW:  d.code = SEL_SW;
      SW_BEQ: d.code = SEL_BEQ;
      SW_RTYPE: begin
        case (btn)
          BTN_ADD: d.code  = SEL_ADD;
          BTN_SUB: d.code  = SEL_SUB;
          BTN_AND: d.code  = SEL_AND;
          BTN_OR:  d.code  = SEL_OR;
          BTN_SLT: d.code  = SEL_SLT;
          default: d.legal = 1'b0;
        endcase
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/board_input_conditioner_if.sv
// Board-side bundle: raw pins in, conditioned instruction select out.
// master = board/stimulus side, slave = conditioner.
interface board_input_conditioner_if;
  logic [3:0] switches;
  logic [2:0] buttons;
  logic [2:0] sel;
  logic       sel_valid;
  logic       sel_changed;
  logic       stable;

  modport master (
    output switches,
    output buttons,
    input  sel,
    input  sel_valid,
    input  sel_changed,
    input  stable
  );

  modport slave (
    input  switches,
    input  buttons,
    output sel,
    output sel_valid,
    output sel_changed,
    output stable
  );
endinterface

// File: rtl/board_input_conditioner_debouncer.sv
// input_debouncer: multi-stage synchronizer followed by a settle counter.
// A synchronized vector is committed once it has been unchanged for
// DEBOUNCE_CYCLES consecutive cycles; commit is a one-cycle strobe.
module input_debouncer
  import board_pkg::*;
#(
  parameter int unsigned WIDTH           = IN_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] deb,
  output logic             commit,
  output logic             stable
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_out;
  logic [WIDTH-1:0]                  cand_q;
  logic [WIDTH-1:0]                  deb_q;
  logic [CntW-1:0]                   cnt_q;
  logic                              commit_q;
  deb_state_e                        state_q;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift raw pins through the synchronizer chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // Settle FSM: any synchronized change restarts the count from zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StSettling;
      cand_q   <= '0;
      deb_q    <= '0;
      cnt_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (sync_out != cand_q) begin
        cand_q  <= sync_out;
        cnt_q   <= '0;
        state_q <= StSettling;
      end else begin
        case (state_q)
          StSettling: begin
            if (cnt_q == CntMax) begin
              deb_q    <= cand_q;
              commit_q <= 1'b1;
              state_q  <= StStable;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StStable: begin
            // Counter holds; value already committed
          end
          default: state_q <= StSettling;
        endcase
      end
    end
  end

  assign deb    = deb_q;
  assign commit = commit_q;
  assign stable = (state_q == StStable);

endmodule

// File: rtl/board_input_conditioner.sv
// board_input_conditioner: synchronizes and debounces the board switches and
// buttons, decodes the committed pattern into a 3-bit instruction select and
// registers it with valid and change strobes.
// Build option HOLD_LAST_VALID_EN: when defined, an illegal committed pattern
// keeps the last legal select running instead of clearing it.
module board_input_conditioner
  import board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input logic                       clk,
  input logic                       reset,
  board_input_conditioner_if.slave  bus
);

  logic [IN_WIDTH-1:0] din;
  logic [IN_WIDTH-1:0] deb;
  logic                commit;
  logic                deb_stable;
  decode_t             dec;

  logic [2:0]          sel_q;
  logic                sel_valid_q;
  logic                sel_changed_q;

  assign din = {bus.switches, bus.buttons};

  input_debouncer #(
    .WIDTH           (IN_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_debouncer (
    .clk    (clk),
    .reset  (reset),
    .din    (din),
    .deb    (deb),
    .commit (commit),
    .stable (deb_stable)
  );

  // deb only moves on commit, so decoding it combinationally is safe
  always_comb begin
    dec = decode_sel(deb[6:3], deb[2:0]);
  end

  // Register the decoded select on each commit; pulse on a new legal value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q         <= SEL_LW;
      sel_valid_q   <= 1'b0;
      sel_changed_q <= 1'b0;
    end else begin
      sel_changed_q <= 1'b0;
      if (commit) begin
        if (dec.legal) begin
          sel_q         <= dec.code;
          sel_valid_q   <= 1'b1;
          sel_changed_q <= (dec.code != sel_q) || !sel_valid_q;
        end else begin
`ifdef HOLD_LAST_VALID_EN
          // Last legal instruction keeps running
`else
          sel_q       <= SEL_LW;
          sel_valid_q <= 1'b0;
`endif
        end
      end
    end
  end

  assign bus.sel         = sel_q;
  assign bus.sel_valid   = sel_valid_q;
  assign bus.sel_changed = sel_changed_q;
  assign bus.stable      = deb_stable;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Bench for board_input_conditioner: a run-length reference model is checked
// every cycle, plus table-driven patterns and hand-written corner sequences.
`timescale 1ns/1ps
module tb_board_input_conditioner;
  localparam int unsigned DC = 4;
  localparam int unsigned SS = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  board_input_conditioner_if bif();

  board_input_conditioner #(
    .DEBOUNCE_CYCLES (DC),
    .SYNC_STAGES     (SS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model state
  logic [6:0] pipe [SS];
  logic [6:0] prev_s;
  logic [6:0] deb_m;
  int         run;
  bit         pend;
  logic [2:0] sel_m;
  bit         valid_m, changed_m, stable_m;

  typedef struct {
    logic [3:0] sw;
    logic [2:0] btn;
    logic [2:0] sel;
    bit         valid;
    int         npulse;
  } vec_t;

  vec_t       tbl [12];
  logic [6:0] pats [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Select code straight from the decode table; -1 means illegal
  function automatic int ref_code(input logic [6:0] v);
    logic [3:0] sw;
    logic [2:0] b;
    sw = v[6:3];
    b  = v[2:0];
    if (sw == 4'b1000) return 0;
    if (sw == 4'b0100) return 1;
    if (sw == 4'b0010) return 2;
    if (sw == 4'b0001) begin
      if (b == 3'b010) return 3;
      if (b == 3'b110) return 4;
      if (b == 3'b000) return 5;
      if (b == 3'b001) return 6;
      if (b == 3'b111) return 7;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SS; i++) pipe[i] = '0;
    prev_s = '0; deb_m = '0; run = 1; pend = 0;
    sel_m = '0; valid_m = 0; changed_m = 0; stable_m = 0;
  endtask

  // A value is committed when it has been seen on DC+1 consecutive edges
  // after leaving the synchronizer; the select follows one edge later.
  task automatic model_edge();
    logic [6:0] s;
    int c;
    changed_m = 0;
    if (pend) begin
      pend = 0;
      c = ref_code(deb_m);
      if (c >= 0) begin
        changed_m = !valid_m || (sel_m != c[2:0]);
        sel_m = c[2:0];
        valid_m = 1;
      end else begin
`ifndef HOLD_LAST_VALID_EN
        sel_m = '0;
        valid_m = 0;
`endif
      end
    end
    s = pipe[SS-1];
    if (s == prev_s) begin
      if (run < int'(DC) + 2) run++;
    end else begin
      run = 1;
      stable_m = 0;
    end
    prev_s = s;
    if (run == int'(DC) + 1) begin
      deb_m = s;
      pend = 1;
      stable_m = 1;
    end
    for (int i = SS - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = {bif.switches, bif.buttons};
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_sel", int'(bif.sel), int'(sel_m));
    chk("model_sel_valid", int'(bif.sel_valid), int'(valid_m));
    chk("model_sel_changed", int'(bif.sel_changed), int'(changed_m));
    chk("model_stable", int'(bif.stable), int'(stable_m));
    pulses += int'(bif.sel_changed);
  endtask

  task automatic drive(input logic [3:0] sw, input logic [2:0] btn);
    bif.switches = sw;
    bif.buttons  = btn;
  endtask

  task automatic hold_and_check(input string name, input int n, input int esel, input int evalid,
                                input int epulse);
    pulses = 0;
    repeat (n) tick();
    chk({name, "_sel"}, int'(bif.sel), esel);
    chk({name, "_valid"}, int'(bif.sel_valid), evalid);
    chk({name, "_pulses"}, pulses, epulse);
  endtask

  initial begin
    logic [2:0] btn;
    int         ill_sel, ill_valid;

`ifdef HOLD_LAST_VALID_EN
    ill_sel = 7; ill_valid = 1;
`else
    ill_sel = 0; ill_valid = 0;
`endif
    tbl[0]  = '{4'b1000, 3'b101, 3'd0, 1, 1};
    tbl[1]  = '{4'b0010, 3'b111, 3'd2, 1, 1};
    tbl[2]  = '{4'b0001, 3'b010, 3'd3, 1, 1};
    tbl[3]  = '{4'b0001, 3'b110, 3'd4, 1, 1};
    tbl[4]  = '{4'b0001, 3'b000, 3'd5, 1, 1};
    tbl[5]  = '{4'b0001, 3'b001, 3'd6, 1, 1};
    tbl[6]  = '{4'b0001, 3'b111, 3'd7, 1, 1};
    tbl[7]  = '{4'b0001, 3'b011, 3'(ill_sel), ill_valid[0], 0};
    tbl[8]  = '{4'b1100, 3'b000, 3'(ill_sel), ill_valid[0], 0};
    tbl[9]  = '{4'b0100, 3'b011, 3'd1, 1, 1};
`ifdef HOLD_LAST_VALID_EN
    tbl[10] = '{4'b0000, 3'b000, 3'd1, 1, 0};
    tbl[11] = '{4'b0100, 3'b000, 3'd1, 1, 0};
`else
    tbl[10] = '{4'b0000, 3'b000, 3'd0, 0, 0};
    tbl[11] = '{4'b0100, 3'b000, 3'd1, 1, 1};
`endif
    pats[0] = 7'b1000_000; pats[1] = 7'b0100_011; pats[2] = 7'b0010_101;
    pats[3] = 7'b0001_010; pats[4] = 7'b0001_110; pats[5] = 7'b0001_000;
    pats[6] = 7'b0001_001; pats[7] = 7'b0001_111;

    // Reset with inputs low
    drive(4'b0000, 3'b000);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_sel", int'(bif.sel), 0);
    chk("rst_valid", int'(bif.sel_valid), 0);
    chk("rst_changed", int'(bif.sel_changed), 0);
    chk("rst_stable", int'(bif.stable), 0);
    reset = 1'b0;
    pulses = 0;
    repeat (10) tick();
    chk("init_pulses", pulses, 0);
    chk("init_valid", int'(bif.sel_valid), 0);
    chk("init_stable", int'(bif.stable), 1);

    // Exact latency of a held pattern: SS + DC + 1 edges after first sample
    drive(4'b0100, 3'b000);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("lat_changed", int'(bif.sel_changed), int'(i == 7));
      chk("lat_valid", int'(bif.sel_valid), int'(i == 7));
    end
    chk("lat_sel", int'(bif.sel), 1);
    tick();
    chk("lat_pulse_width", int'(bif.sel_changed), 0);

    // Table of held patterns
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].sw, tbl[k].btn);
      hold_and_check($sformatf("tbl%0d", k), 12, int'(tbl[k].sel), int'(tbl[k].valid),
                     tbl[k].npulse);
      chk($sformatf("tbl%0d_stable", k), int'(bif.stable), 1);
    end

    // Bouncing buttons never commit; the settled value does
    btn = 3'b110;
    drive(4'b0001, btn);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      repeat (2) tick();
      btn = btn ^ 3'b100;
      drive(4'b0001, btn);
    end
    chk("bounce_pulses", pulses, 0);
    chk("bounce_sel", int'(bif.sel), 1);
    drive(4'b0001, 3'b110);
    hold_and_check("bounce_settle", 12, 4, 1, 1);

    // Illegal pattern from a legal select
    drive(4'b0011, 3'b110);
`ifdef HOLD_LAST_VALID_EN
    hold_and_check("illegal", 12, 4, 1, 0);
`else
    hold_and_check("illegal", 12, 0, 0, 0);
`endif

    // Short glitch then the same legal pattern again
    drive(4'b1000, 3'b000);
    hold_and_check("glitch_pre", 12, 0, 1, 1);
    drive(4'b0100, 3'b000);
    repeat (2) tick();
    drive(4'b1000, 3'b000);
    hold_and_check("glitch_post", 12, 0, 1, 0);
    chk("glitch_stable", int'(bif.stable), 1);

    // Reset in the middle of settling
    drive(4'b0010, 3'b000);
    hold_and_check("midrst_pre", 12, 2, 1, 1);
    drive(4'b1000, 3'b000);
    repeat (2) tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_sel", int'(bif.sel), 0);
    chk("midrst_valid", int'(bif.sel_valid), 0);
    chk("midrst_changed", int'(bif.sel_changed), 0);
    chk("midrst_stable", int'(bif.stable), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midrst_lat_valid", int'(bif.sel_valid), int'(i == 7));
      chk("midrst_lat_changed", int'(bif.sel_changed), int'(i == 7));
    end
    chk("midrst_lat_sel", int'(bif.sel), 0);

    // Random patterns and hold times against the model
    for (int seg = 0; seg < 250; seg++) begin
      logic [6:0] v;
      if ($urandom_range(0, 9) < 7) v = pats[$urandom_range(0, 7)];
      else v = 7'($urandom);
      drive(v[6:3], v[2:0]);
      repeat ($urandom_range(1, 9)) tick();
    end
    repeat (12) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
